// File: rtl/ext_unit_pipe.sv
// ---------------------------------------------------------------------------
// ext_unit_pipe
//
// Purpose:
//   Pipelined extension unit for the MIPS datapath. It extends immediates
//   (sign, zero, LUI-style upper) and selects/extends bytes and halfwords out
//   of loaded words (LB/LBU/LH/LHU), or passes the word through unchanged.
//   The extension itself is combinational on the input side. The result is
//   registered, so a request accepted at edge N is visible in cycle N+1.
//   A 2-entry skid buffer sustains one result per cycle under backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   unit can accept (decoded from state only)
//   in_data    immediate (low IMM_W bits) or loaded word
//   in_mode    operation select (000 sext, 001 zext, 010 upper, 011 LB,
//              100 LBU, 101 LH, 110 LHU, 111 pass)
//   in_off     byte address offset, used by byte/halfword modes only
//   out_valid  result valid
//   out_ready  consumer accepts
//   out_data   extended result
//   out_err    misaligned halfword access flag, qualified by out_valid
// ---------------------------------------------------------------------------
module ext_unit_pipe #(
    parameter int DATA_W     = 32,
    parameter int IMM_W      = 16,
    parameter bit BIG_ENDIAN = 1'b0,
    // Derived from DATA_W; leave at its default.
    parameter int OFF_W      = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_mode,
    input  logic [OFF_W-1:0]  in_off,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mainData_q, mainData_d;
    logic              mainErr_q, mainErr_d;
    logic [DATA_W-1:0] skidData_q, skidData_d;
    logic              skidErr_q, skidErr_d;

    logic [DATA_W-1:0] extData;
    logic              extErr;
    logic [OFF_W-1:0]  byteLane;
    logic [OFF_W-2:0]  halfLane;
    logic [7:0]        selByte;
    logic [15:0]       selHalf;
    logic              inXfer;
    logic              outXfer;

    // Combinational extension of the request currently on the input side.
    // With a power-of-two lane count, (lanes-1-idx) is simply ~idx, which is
    // how the big-endian lane reversal is formed.
    always_comb begin
        extData  = '0;
        extErr   = 1'b0;
        byteLane = BIG_ENDIAN ? ~in_off : in_off;
        halfLane = BIG_ENDIAN ? ~in_off[OFF_W-1:1] : in_off[OFF_W-1:1];
        selByte  = in_data[int'(byteLane) * 8 +: 8];
        selHalf  = in_data[int'(halfLane) * 16 +: 16];
        case (in_mode)
            3'b000: begin
                for (int i = 0; i < DATA_W; i++) begin
                    extData[i] = (i < IMM_W) ? in_data[i] : in_data[IMM_W-1];
                end
            end
            3'b001: begin
                for (int i = 0; i < IMM_W; i++) begin
                    extData[i] = in_data[i];
                end
            end
            3'b010: extData = DATA_W'(in_data[IMM_W-1:0]) << (DATA_W - IMM_W);
            3'b011: extData = {{(DATA_W-8){selByte[7]}}, selByte};
            3'b100: extData = {{(DATA_W-8){1'b0}}, selByte};
            3'b101, 3'b110: begin
                // An odd offset cannot address a halfword: flag it and
                // return zero instead of a partially selected value.
                if (in_off[0]) begin
                    extErr = 1'b1;
                end else if (in_mode == 3'b101) begin
                    extData = {{(DATA_W-16){selHalf[15]}}, selHalf};
                end else begin
                    extData = {{(DATA_W-16){1'b0}}, selHalf};
                end
            end
            default: extData = in_data;
        endcase
    end

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = mainData_q;
    assign out_err   = mainErr_q;

    assign inXfer  = in_valid && in_ready;
    assign outXfer = out_valid && out_ready;

    // Skid-buffer control. M always holds the oldest result and drives the
    // outputs. S only fills when a result arrives while M is stalled, and it
    // moves into M on the next output transfer, which keeps the order FIFO.
    always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        mainErr_d  = mainErr_q;
        skidData_d = skidData_q;
        skidErr_d  = skidErr_q;
        case (state_q)
            EMPTY: begin
                if (inXfer) begin
                    mainData_d = extData;
                    mainErr_d  = extErr;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (inXfer && outXfer) begin
                    mainData_d = extData;
                    mainErr_d  = extErr;
                end else if (inXfer) begin
                    skidData_d = extData;
                    skidErr_d  = extErr;
                    state_d    = FULL;
                end else if (outXfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (outXfer) begin
                    mainData_d = skidData_q;
                    mainErr_d  = skidErr_q;
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            mainData_q <= '0;
            mainErr_q  <= 1'b0;
            skidData_q <= '0;
            skidErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            mainErr_q  <= mainErr_d;
            skidData_q <= skidData_d;
            skidErr_q  <= skidErr_d;
        end
    end

endmodule
